// File: rtl/riscv_pkg.sv
// Shared core types: datapath width, reset vector, fetch bundle.
// Imported by fetch-side and future store-buffer logic.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: imem address/data, redirect, decode handshake.
// master = fetch_buffer side, slave = memory/decode side.
interface fetch_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc_plus4;
  logic [CW-1:0]   occupancy;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_pc_plus4,
    output occupancy
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_pc_plus4,
    input  occupancy
  );
endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// Generic in-order FIFO with flush; caller never pushes when
// full without popping, nor pops when empty.
module sync_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  T                           i_data,
  output T                           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push)
                         - CW'(i_pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: owns fetch PC, buffers {pc,instr} for decode,
// flushes and restarts on redirect.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic            clk,
  input logic            reset,
  fetch_buffer_if.master fb
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic            w_pop;
  logic            w_push;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  assign w_pop  = !w_empty && fb.out_ready;
  assign w_push = !fb.redirect_valid
               && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_pc <= RESET_PC;
    else if (fb.redirect_valid)
      r_pc <= {fb.redirect_pc[XLEN-1:2], 2'b00};
    else if (w_push)
      r_pc <= r_pc + XLEN'(4);
  end

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = fb.imem_rdata;

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (fb.redirect_valid),
    .i_data  (w_wdata),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign fb.imem_addr    = r_pc;
  assign fb.out_valid    = !w_empty;
  assign fb.out_pc       = w_head.pc;
  assign fb.out_instr    = w_head.instr;
  assign fb.out_pc_plus4 = w_head.pc + XLEN'(4);
  assign fb.occupancy    = w_count;
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: queue-level reference model,
// directed phases plus randomized ready/redirect traffic.
module tb_fetch_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC1 = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_buffer_if #(.XLEN(32), .DEPTH(DEPTH)) fb1 ();
  fetch_buffer_if #(.XLEN(32), .DEPTH(DEPTH)) fb2 ();

  assign fb1.imem_rdata = fb1.imem_addr ^ 32'hA5A5_0000;
  assign fb2.imem_rdata = fb2.imem_addr ^ 32'hA5A5_0000;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .fb    (fb1.master)
  );

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
    .clk   (clk),
    .reset (rst_n),
    .fb    (fb2.master)
  );

  int n_pass = 0;
  int n_tot  = 0;

  fetch_entry_t sb[$];
  int           m_cnt;
  logic [31:0]  m_pc;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic m_reset();
    sb.delete();
    m_cnt = 0;
    m_pc  = RPC1;
  endtask

  // Drive inputs for the coming edge, then advance the model.
  task automatic apply(bit rdy, bit rv, logic [31:0] rp);
    bit pop;
    bit push;
    fetch_entry_t e;
    fb1.out_ready      = rdy;
    fb1.redirect_valid = rv;
    fb1.redirect_pc    = rp;
    #2;
    pop = (m_cnt != 0) && rdy;
    if (rv) begin
      sb.delete();
      m_cnt = 0;
      m_pc  = {rp[31:2], 2'b00};
    end else begin
      push  = (m_cnt < DEPTH) || pop;
      m_cnt = m_cnt - int'(pop) + int'(push);
      if (push) begin
        e.pc    = m_pc;
        e.instr = m_pc ^ 32'hA5A5_0000;
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(bit rdy, bit rv, logic [31:0] rp);
    @(negedge clk);
    apply(rdy, rv, rp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fb1.out_ready      = 1'b0;
    fb1.redirect_valid = 1'b0;
    m_reset();
  endtask

  task automatic release_rst(bit rdy);
    @(negedge clk);
    rst_n = 1'b1;
    apply(rdy, 1'b0, 32'h0);
  endtask

  // Monitor: state checks and scoreboard pops on each handshake.
  always @(negedge clk) begin
    fetch_entry_t e;
    #1;
    if (rst_n) begin
      chk("out_valid", {31'b0, fb1.out_valid}, {31'b0, m_cnt != 0});
      chk("occupancy", 32'(fb1.occupancy), 32'(m_cnt));
      chk("imem_addr", fb1.imem_addr, m_pc);
      if (fb1.out_valid && fb1.out_ready) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL pop_no_expected got=pc %h exp=none",
                   fb1.out_pc);
        end else begin
          e = sb.pop_front();
          chk("out_pc", fb1.out_pc, e.pc);
          chk("out_instr", fb1.out_instr, e.instr);
          chk("out_pc_plus4", fb1.out_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  // Wrap-around instance: always ready, never redirected.
  initial begin
    logic [31:0] exp2 [3];
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;
    fb2.out_ready      = 1'b1;
    fb2.redirect_valid = 1'b0;
    fb2.redirect_pc    = '0;
    @(posedge rst_n);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("wrap_valid", {31'b0, fb2.out_valid}, 32'd1);
      chk("wrap_pc", fb2.out_pc, exp2[k]);
      if (k == 1) chk("wrap_plus4", fb2.out_pc_plus4, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    fb1.out_ready      = 1'b0;
    fb1.redirect_valid = 1'b0;
    fb1.redirect_pc    = '0;
    m_reset();
    #22;
    #1;
    chk("rst_valid", {31'b0, fb1.out_valid}, 32'd0);
    chk("rst_occ", 32'(fb1.occupancy), 32'd0);
    chk("rst_addr", fb1.imem_addr, RPC1);

    // Fill with decode stalled, then stream while full.
    release_rst(1'b0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("fill_occ", 32'(fb1.occupancy), 32'd4);
    chk("fill_addr", fb1.imem_addr, 32'h10);
    chk("fill_pc", fb1.out_pc, 32'h0);
    chk("fill_instr", fb1.out_instr, 32'hA5A5_0000);
    chk("fill_plus4", fb1.out_pc_plus4, 32'h4);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Always ready from reset.
    do_reset();
    release_rst(1'b1);
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // Redirect with three entries buffered.
    do_reset();
    release_rst(1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103);
    @(posedge clk);
    #1;
    chk("redir_valid", {31'b0, fb1.out_valid}, 32'd0);
    chk("redir_occ", 32'(fb1.occupancy), 32'd0);
    chk("redir_addr", fb1.imem_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("redir_pc", fb1.out_pc, 32'h100);
    chk("redir_instr", fb1.out_instr, 32'hA5A5_0100);

    // Back-to-back redirects with decode ready.
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0306);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    repeat (400)
      step(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);

    // Asynchronous reset between edges with two entries held.
    do_reset();
    release_rst(1'b0);
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, fb1.out_valid}, 32'd0);
    chk("async_occ", 32'(fb1.occupancy), 32'd0);
    chk("async_addr", fb1.imem_addr, RPC1);
    m_reset();
    release_rst(1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
